// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: issues one imem request at a time,
// holds the returned instruction for the core, and steps the PC on retire.
module pc_fetch_unit #(
    parameter int unsigned       XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP_INSN = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready,
    input  logic            branch,
    input  logic            is_jalr,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] imm,
    output logic            misaligned,
    output logic            halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALT
    } state_t;

    state_t          state, state_d;
    logic [XLEN-1:0] pc, pc_d;
    logic [XLEN-1:0] instr_pc_d;
    logic [31:0]     instr_d;
    logic            instr_valid_d;
    logic            req_valid_d;
    logic            misaligned_d;
    logic            halted_d;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] target;

    assign imem_addr = pc;

    // Next-PC candidate from the branch-unit decision; adds wrap modulo 2^XLEN.
    always_comb begin
        base = is_jalr ? rs1_val : instr_pc;
        sum  = base + imm;
        if (!branch) begin
            target = instr_pc + XLEN'(4);
        end else if (is_jalr) begin
            target = {sum[XLEN-1:1], 1'b0};
        end else begin
            target = sum;
        end
    end

    // Next-state and registered-output values.
    always_comb begin
        state_d       = state;
        pc_d          = pc;
        instr_pc_d    = instr_pc;
        instr_d       = instr;
        instr_valid_d = instr_valid;
        misaligned_d  = misaligned;
        halted_d      = halted;

        unique case (state)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    instr_d       = imem_rdata;
                    instr_pc_d    = pc;
                    instr_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    instr_valid_d = 1'b0;
                    if (target[1]) begin
                        misaligned_d = 1'b1;
                        halted_d     = 1'b1;
                        state_d      = S_HALT;
                    end else begin
                        pc_d    = target;
                        state_d = S_REQ;
                    end
                end
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase

        req_valid_d = (state_d == S_REQ);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
            instr          <= NOP_INSN;
            instr_pc       <= RESET_PC;
            misaligned     <= 1'b0;
            halted         <= 1'b0;
        end else begin
            state          <= state_d;
            pc             <= pc_d;
            imem_req_valid <= req_valid_d;
            instr_valid    <= instr_valid_d;
            instr          <= instr_d;
            instr_pc       <= instr_pc_d;
            misaligned     <= misaligned_d;
            halted         <= halted_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios plus randomized fetch/branch
// traffic checked against a PC model built from the next-PC rules.
module tb_pc_fetch_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_addr;
    logic            imem_resp_valid;
    logic [31:0]     imem_rdata;
    logic            instr_valid;
    logic [31:0]     instr;
    logic [XLEN-1:0] instr_pc;
    logic            instr_ready;
    logic            branch;
    logic            is_jalr;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] imm;
    logic            misaligned;
    logic            halted;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model_pc;
    logic        model_halted;

    pc_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .branch         (branch),
        .is_jalr        (is_jalr),
        .rs1_val        (rs1_val),
        .imm            (imm),
        .misaligned     (misaligned),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a fetch request.
    task automatic wait_req();
        int n;
        n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("req_timeout", imem_req_valid, 32'd1);
    endtask

    // Reference next PC computed from the branch-unit rules.
    function automatic logic [31:0] next_pc(input logic [31:0] ipc, input logic br,
                                            input logic jr, input logic [31:0] r1,
                                            input logic [31:0] im);
        if (!br) return ipc + 32'd4;
        if (jr)  return (r1 + im) & ~32'd1;
        return ipc + im;
    endfunction

    // One full fetch/retire transaction with configurable handshake timing.
    task automatic do_fetch(input int bp, input int rdelay, input int hold,
                            input logic br, input logic jr,
                            input logic [31:0] r1, input logic [31:0] im);
        logic [31:0] rd;
        logic [31:0] t;
        wait_req();
        chk("req_addr", imem_addr, model_pc);
        chk("ivalid_in_req", instr_valid, 32'd0);
        imem_req_ready = 1'b0;
        for (int i = 0; i < bp; i++) begin
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_rdata      = $urandom;
            tick();
            chk("bp_valid", imem_req_valid, 32'd1);
            chk("bp_addr", imem_addr, model_pc);
            chk("bp_ivalid", instr_valid, 32'd0);
        end
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        chk("wait_req_low", imem_req_valid, 32'd0);
        for (int i = 0; i < rdelay; i++) begin
            tick();
            chk("wait_ivalid", instr_valid, 32'd0);
        end
        rd              = $urandom;
        imem_resp_valid = 1'b1;
        imem_rdata      = rd;
        tick();
        imem_resp_valid = 1'b0;
        chk("ivalid", instr_valid, 32'd1);
        chk("instr", instr, rd);
        chk("instr_pc", instr_pc, model_pc);
        for (int i = 0; i < hold; i++) begin
            imem_resp_valid = 1'($urandom_range(0, 1));
            imem_rdata      = $urandom;
            tick();
            chk("hold_instr", instr, rd);
            chk("hold_ivalid", instr_valid, 32'd1);
            chk("hold_req", imem_req_valid, 32'd0);
        end
        imem_resp_valid = 1'b0;
        branch      = br;
        is_jalr     = jr;
        rs1_val     = r1;
        imm         = im;
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        branch      = 1'b0;
        is_jalr     = 1'b0;
        rs1_val     = $urandom;
        imm         = $urandom;
        t = next_pc(model_pc, br, jr, r1, im);
        chk("retire_ivalid", instr_valid, 32'd0);
        if (t[1]) begin
            model_halted = 1'b1;
            chk("mis_flag", misaligned, 32'd1);
            chk("halt_flag", halted, 32'd1);
            chk("halt_no_req", imem_req_valid, 32'd0);
        end else begin
            model_pc = t;
            chk("next_req", imem_req_valid, 32'd1);
            chk("next_addr", imem_addr, t);
            chk("no_mis", misaligned, 32'd0);
        end
    endtask

    initial begin
        logic       kbr;
        logic       kjr;
        logic [31:0] kr1;
        logic [31:0] kim;
        int          kind;

        rst             = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_rdata      = '0;
        instr_ready     = 1'b0;
        branch          = 1'b0;
        is_jalr         = 1'b0;
        rs1_val         = '0;
        imm             = '0;
        model_pc        = 32'h0;
        model_halted    = 1'b0;

        // Reset held three cycles.
        repeat (3) tick();
        chk("rst_req", imem_req_valid, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ivalid", instr_valid, 32'd0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_ipc", instr_pc, 32'h0);
        chk("rst_mis", misaligned, 32'd0);
        chk("rst_halt", halted, 32'd0);
        rst = 1'b0;
        chk("idle_req", imem_req_valid, 32'd0);
        tick();
        chk("first_req", imem_req_valid, 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential fetch 0x0, 0x4, 0x8, then jump to 0x100.
        do_fetch(0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_fetch(0, 0, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("seq_pc8", model_pc, 32'h8);
        do_fetch(0, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0000_00F8);

        // Taken branch back by 8, forward to 0x100 again, then JALR.
        do_fetch(0, 1, 0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFF8);
        chk("beq_addr", imem_addr, 32'h0000_00F8);
        do_fetch(0, 0, 1, 1'b1, 1'b0, 32'h0, 32'h8);
        do_fetch(0, 0, 0, 1'b1, 1'b1, 32'h1001, 32'h3);
        chk("jalr_addr", imem_addr, 32'h0000_1004);

        // Move to the top of the address space and wrap, under 5 cycles of backpressure.
        do_fetch(0, 0, 0, 1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC - 32'h1004);
        chk("top_addr", imem_addr, 32'hFFFF_FFFC);
        do_fetch(5, 2, 0, 1'b0, 1'b0, 32'h0, 32'h0);
        chk("wrap_addr", imem_addr, 32'h0);

        // Randomized traffic with aligned targets.
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 2));
            kbr  = (kind != 0);
            kjr  = (kind == 2);
            kr1  = $urandom & 32'hFFFF_FFFC;
            kim  = {{20{1'b0}}, 10'($urandom_range(0, 1023)), 2'b00};
            if (kjr) kim = kim | 32'($urandom_range(0, 1));
            else if ($urandom_range(0, 1) == 1) kim = -kim;
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), kbr, kjr, kr1, kim);
        end

        // Reset in the middle of WAIT; a late response must be dropped.
        wait_req();
        imem_req_ready = 1'b1;
        tick();
        imem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        model_pc = 32'h0;
        imem_resp_valid = 1'b1;
        imem_rdata      = 32'hDEAD_BEEF;
        chk("rstw_ivalid0", instr_valid, 32'd0);
        tick();
        chk("rstw_ivalid1", instr_valid, 32'd0);
        chk("rstw_req", imem_req_valid, 32'd1);
        chk("rstw_addr", imem_addr, 32'h0);
        tick();
        imem_resp_valid = 1'b0;
        chk("rstw_ivalid2", instr_valid, 32'd0);
        chk("rstw_instr", instr, 32'h0000_0013);

        // Misaligned branch target at 0x100 halts the unit.
        do_fetch(0, 0, 0, 1'b1, 1'b0, 32'h0, 32'h100);
        do_fetch(0, 0, 0, 1'b1, 1'b0, 32'h0, 32'h6);
        chk("model_halt", 32'(model_halted), 32'd1);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("halt_req", imem_req_valid, 32'd0);
            chk("halt_addr", imem_addr, 32'h100);
            chk("halt_sticky", halted, 32'd1);
            chk("mis_sticky", misaligned, 32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
